// File: rtl/common_pkg.sv
// Shared pipeline types.
//   common : architectural register address and data word types.
//   pipes  : pipeline record types built on top of common.
package common;

  localparam int CREG_ADDR_W = 5;
  localparam int WORD_W      = 64;

  typedef logic [CREG_ADDR_W-1:0] creg_addr_t;
  typedef logic [WORD_W-1:0]      word_t;

endpackage : common

package pipes;

  import common::*;

  // One retained writeback: register x0 is never stored as valid.
  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    word_t      data;
  } fwd_entry_t;

endpackage : pipes

// File: rtl/fwd_match.sv
// fwd_match: priority lookup of one source register against the retained
// writeback entries, with an optional same-cycle bypass input that beats
// every stored entry. Entry 0 is youngest and wins over older matches.
module fwd_match
  import common::*;
  import pipes::*;
#(
  parameter int DEPTH  = 2,
  parameter int AGE_W  = 2,
  parameter bit BYPASS = 1'b0
) (
  input  fwd_entry_t       entries [DEPTH],
  input  creg_addr_t       rsrc,
  input  logic             byp_valid,
  input  creg_addr_t       byp_dst,
  input  word_t            byp_data,
  output logic             hit,
  output word_t            data,
  output logic [AGE_W-1:0] age
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hit  = 1'b0;
    data = '0;
    age  = '0;
    if (rsrc != '0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries[i].valid && (entries[i].dst == rsrc)) begin
          hit  = 1'b1;
          data = entries[i].data;
          // With bypass present, stored entries sit one step behind the write.
          age  = AGE_W'(i + int'(BYPASS));
        end
      end
      if (BYPASS && byp_valid && (byp_dst == rsrc)) begin
        hit  = 1'b1;
        data = byp_data;
        age  = '0;
      end
    end
  end

endmodule : fwd_match

// File: rtl/forward_buffer.sv
// forward_buffer: shift register of the last DEPTH writebacks with NREAD
// independent combinational lookup ports.
// Optional feature: define FORWARD_BYPASS_EN to let the write being presented
// this cycle be seen by lookups before it is stored.
module forward_buffer
  import common::*;
  import pipes::*;
#(
  parameter  int DEPTH = 2,
  parameter  int NREAD = 2,
  localparam int AGE_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             flush,
  input  logic             wen,
  input  creg_addr_t       wdst,
  input  word_t            wdata,
  input  creg_addr_t       rsrc  [NREAD],
  output logic [NREAD-1:0] rhit,
  output word_t            rdata [NREAD],
  output logic [AGE_W-1:0] rage  [NREAD],
  output logic [AGE_W-1:0] count
);

`ifdef FORWARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fwd_entry_t       entries [DEPTH];
  logic             byp_valid;
  logic [AGE_W-1:0] valid_cnt;

  // The incoming write is only forwardable when it will really be retained
  // (or would be, were the pipe not stalled); reset masks it entirely.
  assign byp_valid = BYPASS && resetn && wen && (wdst != '0) && !flush;

  // Entry shift register: flush clears valids, stall holds, otherwise push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the entry storage is reset in full (valid, dst and data), not
      // just the valid bits, so no stale value is ever observable after reset.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      // NOTE: state is updated with non-blocking assignments so every entry
      // samples its neighbour's pre-edge value and the shift is order-free.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (!stall) begin
      entries[0] <= '{valid: wen && (wdst != '0), dst: wdst, data: wdata};
      for (int i = DEPTH - 1; i > 0; i--) begin
        entries[i] <= entries[i-1];
      end
    end
  end

  // Popcount of the valid bits.
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt = valid_cnt + AGE_W'(entries[i].valid);
    end
  end

  assign count = valid_cnt;

  // One independent priority matcher per lookup port.
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_match #(
      .DEPTH  (DEPTH),
      .AGE_W  (AGE_W),
      .BYPASS (BYPASS)
    ) u_match (
      .entries   (entries),
      .rsrc      (rsrc[p]),
      .byp_valid (byp_valid),
      .byp_dst   (wdst),
      .byp_data  (wdata),
      .hit       (rhit[p]),
      .data      (rdata[p]),
      .age       (rage[p])
    );
  end

endmodule : forward_buffer

// File: tb/tb_forward_buffer.sv
// Self-checking bench for forward_buffer (DEPTH=2, NREAD=2). The reference
// model is a queue of the most recent writebacks, youngest at the front.
module tb_forward_buffer;

  import common::*;

  localparam int DEPTH = 2;
  localparam int NREAD = 2;
  localparam int AGE_W = $clog2(DEPTH + 1);
`ifdef FORWARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic             stall  = 1'b0;
  logic             flush  = 1'b0;
  logic             wen    = 1'b0;
  creg_addr_t       wdst   = '0;
  word_t            wdata  = '0;
  creg_addr_t       rsrc  [NREAD];
  logic [NREAD-1:0] rhit;
  word_t            rdata [NREAD];
  logic [AGE_W-1:0] rage  [NREAD];
  logic [AGE_W-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [4:0]  dst;
    logic [63:0] data;
  } ment_t;

  ment_t hist[$];

  forward_buffer #(.DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .stall  (stall),
    .flush  (flush),
    .wen    (wen),
    .wdst   (wdst),
    .wdata  (wdata),
    .rsrc   (rsrc),
    .rhit   (rhit),
    .rdata  (rdata),
    .rage   (rage),
    .count  (count)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('{1'b0, 5'd0, 64'd0});
  endfunction

  // What the buffer should do on a rising edge given the current inputs.
  function automatic void model_edge();
    ment_t e;
    if (!resetn) begin
      model_clear();
    end else if (flush) begin
      foreach (hist[i]) hist[i].v = 1'b0;
    end else if (!stall) begin
      e.v    = wen && (wdst != 0);
      e.dst  = wdst;
      e.data = wdata;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endfunction

  function automatic void model_lookup(input logic [4:0] src, output logic h,
                                       output logic [63:0] d, output int a);
    h = 1'b0; d = '0; a = 0;
    if (src == 0 || !resetn) return;
    if (BYP == 1 && wen && wdst == src && !flush) begin
      h = 1'b1; d = wdata; a = 0;
      return;
    end
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i].v && hist[i].dst == src) begin
        h = 1'b1; d = hist[i].data; a = i + BYP;
        return;
      end
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (hist[i]) if (hist[i].v) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model after inputs settle.
  task automatic check_all(input string tag);
    logic        h;
    logic [63:0] d;
    int          a;
    #1;
    for (int p = 0; p < NREAD; p++) begin
      model_lookup(rsrc[p], h, d, a);
      check($sformatf("%s_hit%0d", tag, p), 64'(rhit[p]), 64'(h));
      check($sformatf("%s_data%0d", tag, p), rdata[p], d);
      check($sformatf("%s_age%0d", tag, p), 64'(rage[p]), 64'(a));
    end
    check($sformatf("%s_count", tag), 64'(count), 64'(model_count()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_clear();
    rsrc[0] = 5'd5;
    rsrc[1] = 5'd7;

    // Reset state
    #3;
    check_all("rst");
    check("rst_count", 64'(count), 64'd0);
    resetn = 1'b1;

    // Two writes to x5: the younger wins
    wen = 1'b1; wdst = 5'd5; wdata = 64'h11;
    tick();
    wdata = 64'h22;
    tick();
    wen = 1'b0;
    check_all("x5");
    check("x5_hit", 64'(rhit[0]), 64'd1);
    check("x5_data", rdata[0], 64'h22);
    check("x5_age", 64'(rage[0]), 64'(BYP));
    check("x5_count", 64'(count), 64'd2);

    // x7 ages out after two empty pushes
    wen = 1'b1; wdst = 5'd7; wdata = 64'hAA;
    tick();
    wen = 1'b0;
    tick();
    tick();
    check_all("age_out");
    check("age_out_hit", 64'(rhit[1]), 64'd0);
    check("age_out_count", 64'(count), 64'd0);

    // Writes to x0 are never stored; x0 lookups always miss
    wen = 1'b1; wdst = 5'd0; wdata = 64'hFF;
    tick();
    wen = 1'b0; rsrc[0] = 5'd0;
    check_all("x0");
    check("x0_hit", 64'(rhit[0]), 64'd0);
    check("x0_data", rdata[0], 64'd0);
    check("x0_count", 64'(count), 64'd0);

    // Stall holds contents despite wen; flush under stall empties
    wen = 1'b1; wdst = 5'd1; wdata = 64'h1;
    tick();
    wdst = 5'd2; wdata = 64'h2;
    tick();
    stall = 1'b1; wdst = 5'd9; wdata = 64'h1;
    rsrc[0] = 5'd1; rsrc[1] = 5'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("stall");
    end
    check("stall_age_x1", 64'(rage[0]), 64'(1 + BYP));
    check("stall_count", 64'(count), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; wen = 1'b0;
    check_all("flush");
    check("flush_count", 64'(count), 64'd0);

    // Same-cycle write to a stored register
    wen = 1'b1; wdst = 5'd3; wdata = 64'h10;
    tick();
    wdata = 64'h20; rsrc[1] = 5'd3;
    check_all("bypass");
    check("bypass_data", rdata[1], (BYP == 1) ? 64'h20 : 64'h10);
    check("bypass_age", 64'(rage[1]), 64'd0);
    tick();
    wen = 1'b0;

    // Asynchronous reset between edges with two valid entries
    wen = 1'b1; wdst = 5'd4; wdata = 64'h44;
    tick();
    wdst = 5'd6; wdata = 64'h66;
    tick();
    wen = 1'b0; rsrc[0] = 5'd4; rsrc[1] = 5'd6;
    check_all("pre_arst");
    #2;
    resetn = 1'b0;
    model_clear();
    check_all("arst");
    check("arst_hit", 64'(rhit[1]), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    resetn = 1'b1;
    wen = 1'b1; wdst = 5'd8; wdata = 64'h88;
    tick();
    wen = 1'b0; rsrc[0] = 5'd8;
    check_all("post_arst");
    check("post_arst_age", 64'(rage[0]), 64'(BYP));
    check("post_arst_count", 64'(count), 64'd1);

    // Randomized traffic on a small register range to force collisions
    for (int n = 0; n < 400; n++) begin
      wen      = ($urandom_range(3) != 0);
      wdst     = creg_addr_t'($urandom_range(7));
      wdata    = {$urandom, $urandom};
      stall    = ($urandom_range(4) == 0);
      flush    = ($urandom_range(19) == 0);
      rsrc[0]  = creg_addr_t'($urandom_range(7));
      rsrc[1]  = creg_addr_t'($urandom_range(7));
      check_all("rand");
      if ($urandom_range(49) == 0) begin
        resetn = 1'b0;
        model_clear();
        check_all("rand_arst");
        resetn = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_forward_buffer
